// File: rtl/mux_pkg.sv
// Shared constants for the 2:1 / 4:1 selection block: 4:1 index encodings
// (sel0 is the MSB) and the register reset value.
package mux_pkg;

   localparam logic [1:0] IDX_A = 2'b00;
   localparam logic [1:0] IDX_B = 2'b01;
   localparam logic [1:0] IDX_C = 2'b10;
   localparam logic [1:0] IDX_D = 2'b11;

   // Registered outputs clear to all zeros; replicated to WIDTH at use site.
   localparam logic RST_BIT = 1'b0;

endpackage

// File: rtl/mux_2to1_4to1_if.sv
// Bus bundle for mux_2to1_4to1: enable, data, selects and the four results.
interface mux_2to1_4to1_if #(
   parameter int WIDTH = 1
);

   logic             en;
   logic [WIDTH-1:0] a2, b2;
   logic             sel2;
   logic [WIDTH-1:0] a4, b4, c4, d4;
   logic             sel0, sel1;
   logic [WIDTH-1:0] out2, out4;
   logic [WIDTH-1:0] out2_q, out4_q;

   modport master (
      output en, a2, b2, sel2, a4, b4, c4, d4, sel0, sel1,
      input  out2, out4, out2_q, out4_q
   );

   modport slave (
      input  en, a2, b2, sel2, a4, b4, c4, d4, sel0, sel1,
      output out2, out4, out2_q, out4_q
   );

endinterface

// File: rtl/mux_2to1_cell.sv
// Leaf 2:1 multiplexer; with a known select the chosen leg passes through
// bit-exact and the other leg has no influence.
module mux_2to1_cell #(
   parameter int WIDTH = 1
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sel,
   output logic [WIDTH-1:0] y
);

   assign y = sel ? b : a;

endmodule

// File: rtl/mux_2to1_4to1.sv
// Side-by-side 2:1 and 4:1 multiplexers, each with a combinational output and
// an enabled, asynchronously cleared registered copy.
module mux_2to1_4to1
   import mux_pkg::*;
#(
   parameter int WIDTH = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   mux_2to1_4to1_if.slave    bus
);

   logic [WIDTH-1:0] out2_d, out4_d;
   logic [WIDTH-1:0] ab_y, cd_y;
   logic [WIDTH-1:0] reg2_d, reg2_q;
   logic [WIDTH-1:0] reg4_d, reg4_q;

   mux_2to1_cell #(.WIDTH(WIDTH)) u_mux2 (
      .a(bus.a2), .b(bus.b2), .sel(bus.sel2), .y(out2_d)
   );

   // 4:1 tree: sel1 picks within each pair, sel0 (index MSB) picks the pair.
   mux_2to1_cell #(.WIDTH(WIDTH)) u_mux4_ab (
      .a(bus.a4), .b(bus.b4), .sel(bus.sel1), .y(ab_y)
   );
   mux_2to1_cell #(.WIDTH(WIDTH)) u_mux4_cd (
      .a(bus.c4), .b(bus.d4), .sel(bus.sel1), .y(cd_y)
   );
   mux_2to1_cell #(.WIDTH(WIDTH)) u_mux4_top (
      .a(ab_y), .b(cd_y), .sel(bus.sel0), .y(out4_d)
   );

   // NOTE: every variable written here gets an unconditional value, so no latch.
   always_comb begin
      reg2_d = reg2_q;
      reg4_d = reg4_q;
      if (bus.en) begin
         reg2_d = out2_d;
         reg4_d = out4_d;
      end
   end

   // NOTE: non-blocking assignments keep all registers sampling pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         reg2_q <= {WIDTH{RST_BIT}};
         reg4_q <= {WIDTH{RST_BIT}};
      end else begin
         reg2_q <= reg2_d;
         reg4_q <= reg4_d;
      end
   end

   assign bus.out2   = out2_d;
   assign bus.out4   = out4_d;
   assign bus.out2_q = reg2_q;
   assign bus.out4_q = reg4_q;

endmodule

// File: tb/tb_mux_2to1_4to1.sv
// Directed bench for mux_2to1_4to1: a WIDTH=1 instance for the select tables
// and isolation cases, a WIDTH=8 instance for the registered path and reset.
module tb_mux_2to1_4to1;
   import mux_pkg::*;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_fail;

   mux_2to1_4to1_if #(.WIDTH(1)) b1 ();
   mux_2to1_4to1_if #(.WIDTH(8)) b8 ();

   mux_2to1_4to1 #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
   mux_2to1_4to1 #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(b8));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic set_idx1(input logic [1:0] idx);
      b1.sel0 = idx[1];
      b1.sel1 = idx[0];
   endtask

   // Hand-computed out2 for i = {a2,b2,sel2}, bit i of the constant.
   logic [7:0] exp_out2_tbl;
   logic [1:0] idx_tbl [4];

   initial begin
      n_checks = 0;
      n_fail   = 0;
      exp_out2_tbl = 8'hD8;
      idx_tbl[0] = IDX_A; idx_tbl[1] = IDX_B; idx_tbl[2] = IDX_C; idx_tbl[3] = IDX_D;

      rst_n = 1'b0;
      b1.en = 1'b0; b1.a2 = '0; b1.b2 = '0; b1.sel2 = 1'b0;
      b1.a4 = '0; b1.b4 = '0; b1.c4 = '0; b1.d4 = '0; b1.sel0 = 1'b0; b1.sel1 = 1'b0;
      b8.en = 1'b0; b8.a2 = '0; b8.b2 = '0; b8.sel2 = 1'b0;
      b8.a4 = '0; b8.b4 = '0; b8.c4 = '0; b8.d4 = '0; b8.sel0 = 1'b0; b8.sel1 = 1'b0;

      #3;
      check("rst_out2_q_w8", b8.out2_q, 8'h00);
      check("rst_out4_q_w8", b8.out4_q, 8'h00);
      check("rst_out2_q_w1", {7'd0, b1.out2_q}, 8'h00);
      #4 rst_n = 1'b1;

      // 2:1 exhaustive
      for (int i = 0; i < 8; i++) begin
         logic [2:0] v;
         v = 3'(i);
         b1.a2 = v[2]; b1.b2 = v[1]; b1.sel2 = v[0];
         #1;
         check($sformatf("mux2_%0d", i), {7'd0, b1.out2}, {7'd0, exp_out2_tbl[i]});
      end

      // 4:1 per index, selected leg opposite to the others
      for (int k = 0; k < 4; k++) begin
         for (int v = 0; v < 2; v++) begin
            logic bv;
            bv = (v == 1);
            b1.a4 = ~bv; b1.b4 = ~bv; b1.c4 = ~bv; b1.d4 = ~bv;
            case (k)
               0: b1.a4 = bv;
               1: b1.b4 = bv;
               2: b1.c4 = bv;
               default: b1.d4 = bv;
            endcase
            set_idx1(idx_tbl[k]);
            #1;
            check($sformatf("mux4_idx%0d_v%0d", k, v), {7'd0, b1.out4}, {7'd0, bv});
         end
      end

      // Unselected-leg isolation
      b1.sel2 = 1'b0; b1.b2 = 1'bx; b1.a2 = 1'b1;
      #1 check("iso2_a1", {7'd0, b1.out2}, 8'h01);
      b1.a2 = 1'b0;
      #1 check("iso2_a0", {7'd0, b1.out2}, 8'h00);
      set_idx1(IDX_C);
      b1.a4 = 1'bx; b1.b4 = 1'bx; b1.d4 = 1'bx; b1.c4 = 1'b1;
      #1 check("iso4_c1", {7'd0, b1.out4}, 8'h01);
      b1.c4 = 1'b0;
      #1 check("iso4_c0", {7'd0, b1.out4}, 8'h00);

      // Registered path, WIDTH=8
      @(negedge clk);
      b8.en = 1'b1; b8.sel0 = IDX_A[1]; b8.sel1 = IDX_A[0];
      b8.a4 = 8'hA5; b8.b4 = 8'h11; b8.c4 = 8'h22; b8.d4 = 8'h33;
      b8.a2 = 8'hFF; b8.b2 = 8'h00; b8.sel2 = 1'b0;
      #1;
      check("out4_comb_a5", b8.out4, 8'hA5);
      check("out4_q_pre_edge", b8.out4_q, 8'h00);
      @(posedge clk); #1;
      check("out4_q_a5", b8.out4_q, 8'hA5);
      check("out2_q_ff", b8.out2_q, 8'hFF);
      b8.en = 1'b0; b8.a4 = 8'h3C;
      #1 check("out4_comb_3c", b8.out4, 8'h3C);
      @(posedge clk); #1;
      check("out4_q_hold", b8.out4_q, 8'hA5);
      check("out2_q_hold", b8.out2_q, 8'hFF);

      // Asynchronous reset between edges
      #2 rst_n = 1'b0;
      #1;
      check("arst_out2_q", b8.out2_q, 8'h00);
      check("arst_out4_q", b8.out4_q, 8'h00);
      check("arst_out4_live", b8.out4, 8'h3C);
      b8.en = 1'b1;
      @(posedge clk); #1;
      check("rst_hold_out2_q", b8.out2_q, 8'h00);
      check("rst_hold_out4_q", b8.out4_q, 8'h00);
      #2 rst_n = 1'b1;
      #1 check("rel_pre_edge", b8.out4_q, 8'h00);
      @(posedge clk); #1;
      check("recap_out4_q", b8.out4_q, 8'h3C);
      check("recap_out2_q", b8.out2_q, 8'hFF);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
